uart_send: RTL and testbench

- UART transmitter: serialises one 8-bit byte per frame onto `uart_tx`.
- Frame is 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Paired with the existing UART receiver: same CLK_FREQ/UART_BPS parameterisation and the same bit-period arithmetic, so a loopback link interoperates.
- Byte source (echo logic, command responder) uses a valid/ready handshake.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_send.sv | 158 +++++++++++++++
 tb/tb_uart_send.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: transmit state encoding, frame and
//               counter widths, and the clocks-per-bit helper that the
//               transmitter and receiver both use.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Transmit FSM states. PARITY exists only when UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    // Clocks per bit. Integer division keeps transmitter and receiver in step.
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter. Counts 0..BPS_CNT-1 while enabled and
//               flags the last clock of each bit with o_bit_end. Held at 0
//               while disabled, so every frame starts on a clean bit boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 1736
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic i_en,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] r_clk_cnt;
    logic             w_last;

    assign w_last    = (r_clk_cnt == c_LAST);
    assign o_bit_end = i_en && w_last;

    // Clock counter: runs while enabled, wraps at the end of each bit.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            r_clk_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_send.sv
`default_nettype none
// ============================================================================
// Module      : uart_send
// Description : UART transmitter, 8N1, valid/ready byte input. One byte is
//               accepted in IDLE and shifted out LSB first on a registered
//               line. tx_done pulses in the cycle the FSM returns to IDLE, and
//               a byte accepted in that cycle starts on the next edge.
//               Optional macro UART_TX_PARITY_EN inserts an even-parity bit
//               between the data bits and the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 200_000_000,
    parameter int UART_BPS = 115200,
    parameter int BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS)
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [3:0] c_LAST_BIT = 4'(DATA_BITS - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic       r_tx;
    logic       w_tx_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_bit_cnt_nxt;
    logic       w_bit_end;
    logic       w_cnt_en;
`ifdef UART_TX_PARITY_EN
    logic       r_parity;
    logic       w_parity_nxt;
`endif

    assign w_cnt_en = (r_state != IDLE);

    uart_baud_tick #(
        .BPS_CNT (BPS_CNT)
    ) u_baud_tick (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_en      (w_cnt_en),
        .o_bit_end (w_bit_end)
    );

    // State register plus all registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // Next state, next line level and shift control; the line is registered
    // so the value for each bit is chosen one cycle ahead at the boundary.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_done_nxt    = 1'b0;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_valid) begin
                    w_state_nxt   = START;
                    w_tx_nxt      = 1'b0;
                    w_shift_nxt   = tx_data;
                    w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt  = ^tx_data;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = PARITY;
                        w_tx_nxt      = r_parity;
`else
                        w_state_nxt   = STOP;
                        w_tx_nxt      = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign uart_tx  = r_tx;
    assign tx_done  = r_done;
    assign tx_ready = (r_state == IDLE);
    assign tx_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_send.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_send
// Description : Self-checking bench for uart_send at 10 clocks per bit.
//               Expected line levels come from a frame-level bit list built
//               from each byte, sampled every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_send;

    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BPS;

    logic       clk       = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_send #(
        .CLK_FREQ (1_000_000),
        .UART_BPS (100_000)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Line level expected k clocks after the acceptance edge of byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        logic fb [0:NBITS-1];
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^b;
`endif
        fb[NBITS-1] = 1'b1;
        return fb[k / BPS];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},    uart_tx,  1'b1);
        chk({tag, "_ready"}, tx_ready, 1'b1);
        chk({tag, "_busy"},  tx_busy,  1'b0);
        chk({tag, "_done"},  tx_done,  1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk_idle("idle");
        end
    endtask

    // Present byte b, then check every clock of its frame. With hold set,
    // tx_valid stays high throughout; tx_data switches to mid_data halfway.
    // abort_at >= 0 pulses reset so it is sampled at that clock of the frame.
    task automatic run_frame(input logic [7:0] b, input bit hold,
                             input logic [7:0] mid_data, input int abort_at);
        logic [7:0] sent;
        sent     = b;
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == abort_at) begin
                chk_idle("abort");
                sys_rst_n = 1'b1;
                return;
            end
            if (k < FRAME) begin
                chk("line",  uart_tx,  exp_line(sent, k));
                chk("busy",  tx_busy,  1'b1);
                chk("ready", tx_ready, 1'b0);
                chk("done",  tx_done,  1'b0);
            end else begin
                chk("end_tx",    uart_tx,  1'b1);
                chk("end_done",  tx_done,  1'b1);
                chk("end_ready", tx_ready, 1'b1);
                chk("end_busy",  tx_busy,  1'b0);
            end
            if (k == FRAME / 2) tx_data = mid_data;
            if (k == abort_at - 1) sys_rst_n = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] nb;
        bit         h;

        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        sys_rst_n = 1'b1;
        idle_cycles(50);

        // Directed frame with a one-cycle valid.
        run_frame(8'hA5, 1'b0, 8'h5A, -1);
        idle_cycles(5);

        // Back-to-back: valid held high, data changes mid-frame while busy.
        run_frame(8'h00, 1'b1, 8'hFF, -1);
        run_frame(8'hFF, 1'b0, 8'h12, -1);
        idle_cycles(3);

        // Reset at clock 35 of a frame, then a clean retransmission.
        run_frame(8'h3C, 1'b0, 8'h3C, 35);
        idle_cycles(FRAME + 20);
        run_frame(8'h3C, 1'b0, 8'hC3, -1);
        idle_cycles(2);

        // Randomised bytes, gaps and back-to-back chaining.
        cur = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            h  = 1'($urandom_range(0, 1));
            nb = 8'($urandom);
            run_frame(cur, h, nb, -1);
            if (!h) begin
                idle_cycles($urandom_range(0, 4));
                cur = 8'($urandom);
            end else begin
                cur = nb;
            end
        end
        run_frame(cur, 1'b0, 8'h00, -1);
        idle_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
